// File: rtl/dfr_pkg.sv
// Shared types and default sizes for the DFR input masker.
// The node count default is also used by the reservoir instantiation.
package dfr_pkg;

  localparam int DFR_NODES = 10;
  localparam int DFR_SW    = 16;
  localparam int DFR_MW    = 16;
  localparam int DFR_DW    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dfr_input_masker_if.sv
// Sample handshake, mask write port and reservoir drive bundle.
// master = producer side, slave = the masker itself.
interface dfr_input_masker_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int MASK_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SAMPLE_WIDTH-1:0] in_data;
  logic                    mask_wr_en;
  logic [ADDR_WIDTH-1:0]   mask_wr_addr;
  logic [MASK_WIDTH-1:0]   mask_wr_data;
  logic [DATA_WIDTH-1:0]   res_din;
  logic                    res_en;
  logic                    sample_done;
  logic                    busy;

  modport master (
    output in_valid,
    output in_data,
    output mask_wr_en,
    output mask_wr_addr,
    output mask_wr_data,
    input  in_ready,
    input  res_din,
    input  res_en,
    input  sample_done,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mask_wr_en,
    input  mask_wr_addr,
    input  mask_wr_data,
    output in_ready,
    output res_din,
    output res_en,
    output sample_done,
    output busy
  );

endinterface

// File: rtl/dfr_mask_regfile.sv
// Per-node mask storage: one write port, one combinational read port.
// Reads see the pre-edge value, so a same-cycle write is read-before-write.
module dfr_mask_regfile
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES = DFR_NODES,
  parameter int MASK_WIDTH    = DFR_MW,
  parameter int ADDR_WIDTH    = addr_w(DFR_NODES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [MASK_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [MASK_WIDTH-1:0] rd_data
);

  logic [MASK_WIDTH-1:0] mem [VIRTUAL_NODES];

  // Matching against each index drops out-of-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VIRTUAL_NODES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VIRTUAL_NODES; i++) begin
        if (wr_en && wr_addr == ADDR_WIDTH'(i)) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < VIRTUAL_NODES; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_data = mem[i];
      end
    end
  end

endmodule

// File: rtl/dfr_input_masker.sv
// Accepts one sample, then emits sample*mask[n] for each virtual node
// with a one-cycle res_en strobe per node.
module dfr_input_masker
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES = DFR_NODES,
  parameter int SAMPLE_WIDTH  = DFR_SW,
  parameter int MASK_WIDTH    = DFR_MW,
  parameter int DATA_WIDTH    = DFR_DW
) (
  input logic               clk,
  input logic               rst,
  dfr_input_masker_if.slave bus
);

  localparam int AW = addr_w(VIRTUAL_NODES);
  localparam logic [AW-1:0] LAST = AW'(VIRTUAL_NODES - 1);

  if (DATA_WIDTH != SAMPLE_WIDTH + MASK_WIDTH) begin : g_width_chk
    $error("DATA_WIDTH must equal SAMPLE_WIDTH+MASK_WIDTH");
  end

  state_t                  state;
  state_t                  state_n;
  logic [AW-1:0]           node_idx;
  logic [AW-1:0]           node_n;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [MASK_WIDTH-1:0]   mask_rd;
  logic [DATA_WIDTH-1:0]   product;
  logic [DATA_WIDTH-1:0]   res_din_q;
  logic                    res_en_q;
  logic                    done_q;
  logic                    accept;
  logic                    last_node;

  dfr_mask_regfile #(
    .VIRTUAL_NODES(VIRTUAL_NODES),
    .MASK_WIDTH   (MASK_WIDTH),
    .ADDR_WIDTH   (AW)
  ) u_masks (
    .clk    (clk),
    .rst_n  (rst),
    .wr_en  (bus.mask_wr_en),
    .wr_addr(bus.mask_wr_addr),
    .wr_data(bus.mask_wr_data),
    .rd_addr(node_idx),
    .rd_data(mask_rd)
  );

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_node = (node_idx == LAST);
  assign product   = DATA_WIDTH'(sample_q) * DATA_WIDTH'(mask_rd);

  always_comb begin
    state_n = state;
    node_n  = node_idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = RUN;
          node_n  = '0;
        end
      end
      RUN: begin
        if (last_node) begin
          state_n = IDLE;
          node_n  = '0;
        end else begin
          node_n = node_idx + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        node_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      node_idx  <= '0;
      sample_q  <= '0;
      res_din_q <= '0;
      res_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_n;
      node_idx <= node_n;
      res_en_q <= (state == RUN);
      done_q   <= (state == RUN) && last_node;
      if (accept) begin
        sample_q <= bus.in_data;
      end
      if (state == RUN) begin
        res_din_q <= product;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.res_din     = res_din_q;
  assign bus.res_en      = res_en_q;
  assign bus.sample_done = done_q;

endmodule

// File: tb/tb_dfr_input_masker.sv
// Directed bench for dfr_input_masker with hand-computed expectations.
module tb_dfr_input_masker;

  localparam int VN = 10;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;
  logic [15:0] mask_m [VN];

  dfr_input_masker_if #(
    .SAMPLE_WIDTH(16),
    .MASK_WIDTH  (16),
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (AW)
  ) bus ();

  dfr_input_masker #(
    .VIRTUAL_NODES(VN),
    .SAMPLE_WIDTH (16),
    .MASK_WIDTH   (16),
    .DATA_WIDTH   (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mask(input logic [3:0] a, input logic [15:0] d);
    bus.mask_wr_en   = 1'b1;
    bus.mask_wr_addr = a;
    bus.mask_wr_data = d;
    tick();
    bus.mask_wr_en   = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < VN; i++) begin
      wr_mask(4'(i), 16'(i + 1));
      mask_m[i] = 16'(i + 1);
    end
  endtask

  task automatic send_check(input string tag, input logic [15:0] s);
    logic [63:0] exp;
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_lat"}, 64'(bus.res_en), 64'd0);
    for (int k = 0; k < VN; k++) begin
      tick();
      exp = 64'(s) * 64'(mask_m[k]);
      chk($sformatf("%s_en%0d", tag, k), 64'(bus.res_en), 64'd1);
      chk($sformatf("%s_d%0d", tag, k), 64'(bus.res_din), exp);
      chk($sformatf("%s_done%0d", tag, k), 64'(bus.sample_done),
          64'(k == VN - 1));
      chk($sformatf("%s_ir%0d", tag, k), 64'(bus.in_ready),
          64'(k == VN - 1));
    end
    tick();
    chk({tag, "_end"}, 64'(bus.res_en), 64'd0);
    chk({tag, "_hold"}, 64'(bus.res_din), exp);
  endtask

  initial begin
    int pulses;
    cmp_cnt          = 0;
    err_cnt          = 0;
    rst              = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.mask_wr_en   = 1'b0;
    bus.mask_wr_addr = '0;
    bus.mask_wr_data = '0;
    for (int i = 0; i < VN; i++) mask_m[i] = '0;

    // reset state
    #3;
    chk("rst_en", 64'(bus.res_en), 64'd0);
    chk("rst_din", 64'(bus.res_din), 64'd0);
    chk("rst_done", 64'(bus.sample_done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);

    // 1: ramp masks, sample 3
    load_ramp();
    send_check("t1", 16'h0003);

    // 2: full-width product
    wr_mask(4'd0, 16'hFFFF);
    mask_m[0] = 16'hFFFF;
    send_check("t2", 16'hFFFF);

    // 3: back-to-back with held valid
    for (int i = 0; i < VN; i++) begin
      wr_mask(4'(i), 16'd1);
      mask_m[i] = 16'd1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd2;
    tick();
    bus.in_data = 16'd5;
    for (int k = 0; k < VN; k++) begin
      tick();
      chk($sformatf("t3a_d%0d", k), 64'(bus.res_din), 64'd2);
      chk($sformatf("t3a_en%0d", k), 64'(bus.res_en), 64'd1);
    end
    tick();
    bus.in_valid = 1'b0;
    chk("t3_gap", 64'(bus.res_en), 64'd0);
    chk("t3_gap_busy", 64'(bus.busy), 64'd1);
    for (int k = 0; k < VN; k++) begin
      tick();
      chk($sformatf("t3b_d%0d", k), 64'(bus.res_din), 64'd5);
      chk($sformatf("t3b_en%0d", k), 64'(bus.res_en), 64'd1);
    end
    tick();
    chk("t3_end", 64'(bus.res_en), 64'd0);

    // 4: write during RUN, read-before-write, out-of-range write
    load_ramp();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < VN; k++) begin
      bus.mask_wr_en = 1'b0;
      if (k == 4) begin
        bus.mask_wr_en   = 1'b1;
        bus.mask_wr_addr = 4'd4;
        bus.mask_wr_data = 16'h0100;
      end
      if (k == 6) begin
        bus.mask_wr_en   = 1'b1;
        bus.mask_wr_addr = 4'd12;
        bus.mask_wr_data = 16'hFFFF;
      end
      tick();
      chk($sformatf("t4_d%0d", k), 64'(bus.res_din), 64'(k + 1));
    end
    bus.mask_wr_en = 1'b0;
    tick();
    mask_m[4] = 16'h0100;
    send_check("t4b", 16'd1);

    // 5: async reset mid-RUN
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("t5_pre_en", 64'(bus.res_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_en", 64'(bus.res_en), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_done", 64'(bus.sample_done), 64'd0);
    chk("t5_din", 64'(bus.res_din), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t5_rdy", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < VN; i++) mask_m[i] = '0;
    send_check("t5z", 16'h1234);

    // 6: valid toggling while not ready
    load_ramp();
    pulses = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd2;
    tick();
    for (int k = 0; k < VN; k++) begin
      bus.in_valid = k[0];
      bus.in_data  = 16'(100 + k);
      tick();
      if (bus.res_en) pulses++;
      chk($sformatf("t6_d%0d", k), 64'(bus.res_din), 64'(2 * (k + 1)));
    end
    bus.in_valid = 1'b0;
    repeat (4) begin
      tick();
      if (bus.res_en) pulses++;
    end
    chk("t6_pulses", 64'(pulses), 64'd10);
    chk("t6_idle", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
